// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared types and helpers for the time-shared divider.
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Requester IDs
    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // Step counter must hold the value WIDTH without wrapping
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_iter_core.sv
`default_nettype none
// ============================================================================
// Module      : div_iter_core
// Description : Restoring unsigned divide datapath, one quotient bit per step.
//               A zero divisor loads the divide-by-zero result directly.
// Revision    : 1.0 - initial release
// ============================================================================
module div_iter_core
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last_step,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);

    localparam int              CW     = cnt_width(WIDTH);
    localparam logic [CW-1:0]   c_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;

    // The remainder never reaches 2^WIDTH between steps (it stays below b),
    // so its top bit is always zero and only WIDTH bits are stored.
    assign w_shift   = {r_r, r_q[WIDTH-1]};
    assign w_trial   = w_shift - {1'b0, r_b};
    assign last_step = step && (r_cnt == c_LAST);

    assign quot = r_q;
    assign rem  = r_r;

    // Load operands on accept, then shift/subtract once per step
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_q   <= '0;
            r_r   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
        end else if (load) begin
            r_b   <= b;
            r_cnt <= '0;
            if (b == '0) begin
                r_q <= '1;
                r_r <= a;
            end else begin
                r_q <= a;
                r_r <= '0;
            end
        end else if (step) begin
            r_q   <= {r_q[WIDTH-2:0], ~w_trial[WIDTH]};
            r_r   <= w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/div_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : div_arbiter
// Description : Two-requester round-robin front end for a shared sequential
//               divider, with a valid/ready response port.
// Revision    : 1.0 - initial release
// ============================================================================
module div_arbiter
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_quot,
    output logic [WIDTH-1:0] resp_rem,
    output logic             resp_dbz
);

    state_t           r_state;
    logic             r_last;
    logic             r_valid;
    logic             r_id;
    logic             r_dbz;

    logic             w_grant;
    logic             w_accept;
    logic             w_step;
    logic             w_last_step;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;

    // Round-robin: on a tie the requester not served last wins
    always_comb begin
        w_grant = REQ0;
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last;
        end else if (req1_valid) begin
            w_grant = REQ1;
        end
    end

    assign w_accept   = reset_n && (r_state == ST_IDLE) && (req0_valid || req1_valid);
    assign req0_ready = w_accept && (w_grant == REQ0);
    assign req1_ready = w_accept && (w_grant == REQ1);
    assign w_a        = (w_grant == REQ1) ? req1_a : req0_a;
    assign w_b        = (w_grant == REQ1) ? req1_b : req0_b;
    assign w_step     = (r_state == ST_RUN);

    assign resp_valid = r_valid;
    assign resp_id    = r_id;
    assign resp_dbz   = r_dbz;

    div_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (w_accept),
        .step      (w_step),
        .a         (w_a),
        .b         (w_b),
        .last_step (w_last_step),
        .quot      (resp_quot),
        .rem       (resp_rem)
    );

    // Controller FSM with registered response flags
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_last  <= REQ1;
            r_valid <= 1'b0;
            r_id    <= REQ0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_id  <= w_grant;
                        r_dbz <= (w_b == '0);
                        if (w_b == '0) begin
                            r_state <= ST_DONE;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_last_step) begin
                        r_state <= ST_DONE;
                        r_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (resp_ready) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_last  <= r_id;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
